// File: rtl/sa_autosa_mcif_rd_wrr_arb.sv
// Weighted round-robin read-request arbiter for the MCIF read path.
// Optional perf counters: define SA_AUTOSA_MCIF_RD_ARB_PERF_EN.
module sa_autosa_mcif_rd_wrr_arb #(
   parameter int NUM_REQ = 4,
   parameter int PD_W    = 79,
   parameter int ID_W    = 3
) (
   input  logic                    autosa_core_clk,
   input  logic                    autosa_core_rstn,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*PD_W-1:0] req_pd,
   input  logic [NUM_REQ*8-1:0]    reg2dp_rd_weight,
   input  logic [7:0]              reg2dp_rd_os_cnt,
   output logic                    arb_valid,
   input  logic                    arb_ready,
   output logic [PD_W-1:0]         arb_pd,
   output logic [ID_W-1:0]         arb_id,
   input  logic                    rsp_done,
   output logic                    dp2reg_idle,
   output logic                    os_underflow,
   output logic [31:0]             perf_grant_cnt,
   output logic [31:0]             perf_stall_cnt
);

   logic [7:0]         credit [NUM_REQ];
   logic [7:0]         eff_w  [NUM_REQ];
   logic [ID_W-1:0]    rr_ptr;
   logic [8:0]         os_cur;
   logic [8:0]         lim;
   logic [NUM_REQ-1:0] elig_raw;
   logic [NUM_REQ-1:0] elig;
   logic               slot_free;
   logic               can_issue;
   logic               any_valid;
   logic               refill;
   logic               found;
   logic               grant;
   logic [ID_W-1:0]    win;
   logic [PD_W-1:0]    win_pd;

   assign slot_free = !arb_valid | arb_ready;
   assign lim       = {1'b0, reg2dp_rd_os_cnt} + 9'd1;
   assign can_issue = slot_free & (os_cur < lim);
   assign any_valid = |req_valid;
   assign refill    = any_valid & ~(|elig_raw);
   assign elig      = refill ? req_valid : elig_raw;
   assign grant     = can_issue & found;

   // Effective weights and credit-based eligibility per client
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         eff_w[i] = (reg2dp_rd_weight[i*8 +: 8] == 8'd0) ?
                    8'd1 : reg2dp_rd_weight[i*8 +: 8];
         elig_raw[i] = req_valid[i] & (credit[i] != 8'd0);
      end
   end

   // Pick the first eligible client after rr_ptr, wrapping
   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = ID_W'(idx);
         end
      end
   end

   // Payload mux and one-hot ready for the winner
   always_comb begin
      win_pd    = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == win) begin
            win_pd       = req_pd[i*PD_W +: PD_W];
            req_ready[i] = grant;
         end
      end
   end

   // Credit bookkeeping: reload on refill, consume on grant
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         for (int i = 0; i < NUM_REQ; i++) credit[i] <= 8'd0;
      end else if (grant) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (refill) begin
               credit[i] <= (ID_W'(i) == win) ?
                            eff_w[i] - 8'd1 : eff_w[i];
            end else if (ID_W'(i) == win) begin
               credit[i] <= credit[i] - 8'd1;
            end
         end
      end
   end

   // Round-robin pointer follows the last winner
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         rr_ptr <= ID_W'(NUM_REQ - 1);
      end else if (grant) begin
         rr_ptr <= win;
      end
   end

   // Single-entry output register with pass-through refill
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         arb_valid <= 1'b0;
         arb_pd    <= '0;
         arb_id    <= '0;
      end else if (slot_free) begin
         arb_valid <= grant;
         if (grant) begin
            arb_pd <= win_pd;
            arb_id <= win;
         end
      end
   end

   // Outstanding-read counter with sticky underflow detection
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         os_cur       <= 9'd0;
         os_underflow <= 1'b0;
      end else begin
         unique case ({grant, rsp_done})
            2'b10: os_cur <= os_cur + 9'd1;
            2'b01: begin
               if (os_cur == 9'd0) os_underflow <= 1'b1;
               else                os_cur       <= os_cur - 9'd1;
            end
            default: ;
         endcase
      end
   end

   // Registered idle indication back to the register block
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         dp2reg_idle <= 1'b1;
      end else begin
         dp2reg_idle <= !arb_valid & (os_cur == 9'd0) & !any_valid;
      end
   end

`ifdef SA_AUTOSA_MCIF_RD_ARB_PERF_EN
   logic [31:0] grant_cnt;
   logic [31:0] stall_cnt;

   // Saturating accept and stall counters
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         grant_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (arb_valid && arb_ready && grant_cnt != 32'hFFFF_FFFF)
            grant_cnt <= grant_cnt + 32'd1;
         if (any_valid && !grant && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign perf_grant_cnt = grant_cnt;
   assign perf_stall_cnt = stall_cnt;
`else
   assign perf_grant_cnt = 32'd0;
   assign perf_stall_cnt = 32'd0;
`endif

endmodule
